uart_rx_oversampled: RTL and testbench
======================================

# uart_rx_oversampled

Serial receiver for the DE0-Nano ↔ Raspberry Pi UART link; the receive-side counterpart of the transmit path's baud tick generation. It derives an oversampling tick from the system clock with a fractional phase accumulator, synchronises the asynchronous `rxd` line, and finds start bits. It samples each bit at mid-period, checks stop-bit framing, and presents each received byte as a single-cycle strobe to the fabric.

## Interface
- `ClkFrequency`, 50000000: system clock frequency in Hz.
- `Baud`, 460800: line bit rate.
- `Oversampling`, 8: ticks per bit period; power of two, 4..16.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `rxd`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  last good byte, LSB first on the wire; reset 8'h00; holds until next good byte.
- `rx_valid`  out  1  one-cycle strobe, `rx_data` updated this cycle; reset 0.
- `frame_err`  out  1  one-cycle strobe, stop bit sampled low; reset 0.
- `rx_busy`  out  1  high from start-bit confirm until return to IDLE; reset 0.

## Operation
- Tick generator:
  - AccWidth = ceil(log2(ClkFrequency/Baud)) + 8.
  - Inc = round(Baud·Oversampling·2^AccWidth / ClkFrequency), computed without 32-bit overflow by pre-shift.
  - The (AccWidth+1)-bit accumulator adds Inc every clock, keeping only the low AccWidth bits.
  - `tick` is the carry bit, so it is a one-clock pulse. Free-running.
  - Accumulator is cleared to 0 by reset.
- Input synchroniser: two flops, reset to 1; `rxs` is the second stage. All decisions use `rxs`, and only on `tick` cycles.
- FSM states IDLE, START, DATA, STOP, BREAK. `cnt` is a tick counter (log2(Oversampling) bits); `bitn` is 3 bits.
  - IDLE: `rxs`=0 on a tick → START, cnt=0.
  - START: at cnt = Oversampling/2−1, if `rxs`=0 → DATA, cnt=0, bitn=0, `rx_busy`=1. Otherwise it is a false start → IDLE, with no strobe.
  - DATA: at cnt = Oversampling−1, shift `rxs` into shift[7] (right shift).
    - bitn=7 → STOP; otherwise bitn++.
  - STOP: at cnt = Oversampling−1:
    - `rxs`=1 → `rx_data`←shift, `rx_valid`=1, → IDLE.
    - `rxs`=0 → `frame_err`=1, `rx_data` unchanged, → BREAK.
  - BREAK: stay until `rxs`=1 on a tick → IDLE. This prevents a held-low line from producing repeated frames.
- `rx_valid` and `frame_err` are never high together.
- Reset mid-frame: FSM→IDLE immediately, partial byte discarded, no strobe after release.

## Timing
- `rxd` → `rxs`: 2 clk.
- Phase uncertainty of start detection: ≤1 tick, i.e. 1/Oversampling bit. Nominal sample point ≥ mid-bit ±1/16 bit at Oversampling=8.
- `rx_valid` is registered: high on the clock after the stop-bit sampling tick, for exactly 1 clk.
- Frame acceptance to `rx_valid`: ≈9.5 bit periods + 2–3 clk after the start-bit falling edge.
- Back-to-back frames (stop followed immediately by start) must be received with no gap. STOP exits at mid-stop-bit, so IDLE sees the next falling edge.
- Baud tolerance: bytes are received correctly with ±2% rate mismatch.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - adds a PARITY state between DATA and STOP, sampling one even-parity bit;
  - adds output `parity_err` (1-bit strobe, reset 0).
  - On mismatch with a good stop bit: `parity_err`=1, `rx_valid`=0, `rx_data` unchanged.
  - A framing error takes precedence (only `frame_err` pulses).
- Undefined: 8N1 only, no `parity_err` port.

## Test plan
- Reset/idle: `rst_n` low 5 clk, `rxd`=1 → all outputs 0, `rx_data`=8'h00, no strobes for 2000 clk.
- Single byte: send 8'hA5 at 460800 baud (2170 ns/bit) → one `rx_valid` pulse 1 clk wide, `rx_data`=8'hA5, `frame_err` never high.
- Back-to-back with rate error: 16 bytes 8'h00..8'h0F, no idle gap, bit period 2127 ns then 2213 ns (±2%) → 16 `rx_valid` pulses, values in order.
- Glitch and framing:
  - a 500 ns low pulse on idle line → no strobe, `rx_busy` stays 0;
  - 8'h3C with stop bit low, then line held low 20 µs → exactly one `frame_err`, no `rx_valid`, `rx_data` keeps its previous value.
- Reset mid-frame: assert `rst_n` during bit 4 of 8'hFF, release, then send 8'h12 → only `rx_valid` with 8'h12.
- With `UART_RX_PARITY_EN`: 8'h07 with parity 1 → `rx_valid`, `rx_data`=8'h07; same byte with parity 0 → `parity_err` pulse, no `rx_valid`.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampled 8N1 UART receiver (8E1 with UART_RX_PARITY_EN).
// Ports: clk, rst_n (async, active-low), rxd (async serial line, idle high);
//   rx_data (last good byte), rx_valid / frame_err (1-clk strobes),
//   rx_busy (frame in progress), parity_err (only with UART_RX_PARITY_EN).
// Optional macro: UART_RX_PARITY_EN adds one even-parity bit before stop.
module uart_rx_oversampled #(
  parameter int ClkFrequency = 50000000,
  parameter int Baud         = 460800,
  parameter int Oversampling = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int AccWidth =
    $clog2((ClkFrequency + Baud - 1) / Baud) + 8;
  // 64-bit math keeps Baud*Oversampling<<AccWidth from overflowing.
  localparam longint IncL =
    ((longint'(Baud) * longint'(Oversampling) << AccWidth)
     + longint'(ClkFrequency / 2)) / longint'(ClkFrequency);
  localparam logic [AccWidth:0] Inc = (AccWidth+1)'(IncL);

  localparam int Cw = $clog2(Oversampling);
  localparam logic [Cw-1:0] CntHalf = Cw'(Oversampling / 2 - 1);
  localparam logic [Cw-1:0] CntLast = Cw'(Oversampling - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic [AccWidth:0] r_acc;
  logic              w_tick;
  logic [1:0]        r_sync;
  logic              w_rxs;

  state_t            r_state, w_state_n;
  logic [Cw-1:0]     r_cnt, w_cnt_n;
  logic [2:0]        r_bitn, w_bitn_n;
  logic [7:0]        r_shift, w_shift_n;
  logic [7:0]        r_data, w_data_n;
  logic              r_valid, w_valid_n;
  logic              r_ferr, w_ferr_n;
  logic              r_busy, w_busy_n;
  logic              w_par_bad;
  state_t            w_after_data;

`ifdef UART_RX_PARITY_EN
  logic              r_par, w_par_n;
  logic              r_perr, w_perr_n;
  assign w_par_bad    = ^{r_shift, r_par};
  assign w_after_data = S_PARITY;
  assign parity_err   = r_perr;
`else
  assign w_par_bad    = 1'b0;
  assign w_after_data = S_STOP;
`endif

  // Carry out of the low AccWidth bits is the oversampling tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= {1'b0, r_acc[AccWidth-1:0]} + Inc;
    end
  end

  assign w_tick = r_acc[AccWidth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rxd};
    end
  end

  assign w_rxs = r_sync[1];

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bitn_n  = r_bitn;
    w_shift_n = r_shift;
    w_data_n  = r_data;
    w_valid_n = 1'b0;
    w_ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_n   = r_par;
    w_perr_n  = 1'b0;
`endif
    if (w_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            w_state_n = S_START;
            w_cnt_n   = '0;
          end
        end
        S_START: begin
          if (r_cnt == CntHalf) begin
            // Line back high at mid start bit: glitch.
            w_state_n = w_rxs ? S_IDLE : S_DATA;
            w_cnt_n   = '0;
            w_bitn_n  = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == CntLast) begin
            w_cnt_n   = '0;
            w_shift_n = {w_rxs, r_shift[7:1]};
            if (r_bitn == 3'd7) begin
              w_state_n = w_after_data;
            end else begin
              w_bitn_n = r_bitn + 3'd1;
            end
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == CntLast) begin
            w_cnt_n   = '0;
            w_par_n   = w_rxs;
            w_state_n = S_STOP;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (r_cnt == CntLast) begin
            w_cnt_n = '0;
            // Leave at mid-stop so the next start edge is seen.
            if (w_rxs) begin
              w_state_n = S_IDLE;
              if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
                w_perr_n = 1'b1;
`endif
              end else begin
                w_data_n  = r_shift;
                w_valid_n = 1'b1;
              end
            end else begin
              w_ferr_n  = 1'b1;
              w_state_n = S_BREAK;
            end
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (w_rxs) begin
            w_state_n = S_IDLE;
          end
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
    w_busy_n = (w_state_n != S_IDLE) && (w_state_n != S_START);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bitn  <= w_bitn_n;
      r_shift <= w_shift_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_ferr  <= w_ferr_n;
      r_busy  <= w_busy_n;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_n;
      r_perr  <= w_perr_n;
`endif
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign rx_busy   = r_busy;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: directed + randomized frames for uart_rx_oversampled,
// checked against a byte-level expectation model.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

  localparam int BitNs = 2170;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       rxd   = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
  int         n_perr   = 0;
  int         exp_perr = 0;
`endif

  int checks   = 0;
  int failures = 0;

  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_wide  = 0;
  int         n_both  = 0;
  int         n_busy  = 0;
  logic       prev_v  = 1'b0;
  logic [7:0] got_arr [256];

  logic [7:0] exp_q [$];
  int         exp_ferr  = 0;
  logic [7:0] last_good = 8'h00;
  int         rd        = 0;

  uart_rx_oversampled dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (n_valid < 256) got_arr[n_valid] = rx_data;
      n_valid++;
    end
    if (rx_valid && prev_v) n_wide++;
    if (rx_valid && frame_err) n_both++;
    if (frame_err) n_ferr++;
    if (rx_busy) n_busy++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_perr++;
`endif
    prev_v = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input int bns,
                             input logic stop);
    rxd = 1'b0;
    #(bns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bns);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ par_flip;
    #(bns);
`endif
    rxd = stop;
    #(bns);
  endtask

  // Model: a frame with a good stop bit (and good parity) yields its byte.
  task automatic send_byte(input logic [7:0] b, input int bns,
                           input logic stop);
    drive_frame(b, bns, stop);
    if (!stop) begin
      exp_ferr++;
`ifdef UART_RX_PARITY_EN
    end else if (par_flip) begin
      exp_perr++;
`endif
    end else begin
      exp_q.push_back(b);
      last_good = b;
    end
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_count"}, 32'(n_valid - rd), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      logic [31:0] g;
      e = exp_q.pop_front();
      g = (rd < n_valid && rd < 256) ? 32'(got_arr[rd]) : 32'hDEAD;
      chk({tag, "_byte"}, g, 32'(e));
      rd++;
    end
    rd = n_valid;
  endtask

  initial begin
    int nv;
    int nb;
    int p;
    logic [7:0] b;

    #1 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(rx_busy), 32'h0);
    rst_n = 1'b1;
    repeat (2000) @(negedge clk);
    chk("idle_valid", 32'(n_valid), 32'h0);
    chk("idle_ferr", 32'(n_ferr), 32'h0);
    chk("idle_busy", 32'(n_busy), 32'h0);
    chk("idle_data", 32'(rx_data), 32'h00);

    send_byte(8'hA5, BitNs, 1'b1);
    #(2 * BitNs);
    check_rx("single");
    chk("single_data", 32'(rx_data), 32'(last_good));
    chk("single_ferr", 32'(n_ferr), 32'(exp_ferr));
    chk("single_wide", 32'(n_wide), 32'h0);

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_byte(b, BitNs - 40 + int'($urandom_range(0, 80)), 1'b1);
      #(BitNs * int'($urandom_range(0, 3)));
    end
    #(2 * BitNs);
    check_rx("rand");
    chk("rand_data", 32'(rx_data), 32'(last_good));

    for (int i = 0; i < 16; i++) send_byte(8'(i), 2127, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 2213, 1'b1);
    #(2 * BitNs);
    check_rx("b2b");

    p = int'($urandom_range(2130, 2210));
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), p, 1'b1);
    #(2 * BitNs);
    check_rx("burst");
    chk("burst_wide", 32'(n_wide), 32'h0);

    nb = n_busy;
    nv = n_valid;
    rxd = 1'b0;
    #500;
    rxd = 1'b1;
    #(5 * BitNs);
    chk("glitch_busy", 32'(n_busy), 32'(nb));
    chk("glitch_valid", 32'(n_valid), 32'(nv));
    chk("glitch_ferr", 32'(n_ferr), 32'(exp_ferr));

    send_byte(8'h3C, BitNs, 1'b0);
    #20000;
    rxd = 1'b1;
    #(3 * BitNs);
    chk("ferr_count", 32'(n_ferr), 32'(exp_ferr));
    check_rx("ferr");
    chk("ferr_data", 32'(rx_data), 32'(last_good));
    chk("ferr_both", 32'(n_both), 32'h0);

    send_byte(8'($urandom), BitNs, 1'b1);
    #(2 * BitNs);
    check_rx("recover");

    nv = n_valid;
    fork
      drive_frame(8'hFF, BitNs, 1'b1);
      begin
        #(5 * BitNs + BitNs / 2);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    last_good = 8'h00;
    chk("midrst_data", 32'(rx_data), 32'h00);
    chk("midrst_busy", 32'(rx_busy), 32'h0);
    #(2 * BitNs);
    chk("midrst_valid", 32'(n_valid), 32'(nv));
    send_byte(8'h12, BitNs, 1'b1);
    #(2 * BitNs);
    check_rx("after_rst");
    chk("after_rst_data", 32'(rx_data), 32'h12);

`ifdef UART_RX_PARITY_EN
    par_flip = 1'b0;
    send_byte(8'h07, BitNs, 1'b1);
    #(2 * BitNs);
    check_rx("par_ok");
    chk("par_ok_data", 32'(rx_data), 32'h07);
    par_flip = 1'b1;
    send_byte(8'h07, BitNs, 1'b1);
    par_flip = 1'b0;
    #(2 * BitNs);
    chk("par_err_count", 32'(n_perr), 32'(exp_perr));
    check_rx("par_bad");
    chk("par_bad_data", 32'(rx_data), 32'(last_good));
`endif

    chk("final_both", 32'(n_both), 32'h0);
    chk("final_wide", 32'(n_wide), 32'h0);
    chk("final_ferr", 32'(n_ferr), 32'(exp_ferr));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
